// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad event bridge: event byte layout, serialiser states, defaults.
// Latency/backpressure: n/a (types and constants only).
package keypad_pkg;

  localparam int RELEASE_BIT        = 7;
  localparam int INDEX_MSB          = 6;
  localparam int IW                 = INDEX_MSB + 1;
  localparam int SCAN_DIV_DEF       = 1000;
  localparam int DEBOUNCE_SCANS_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } ser_state_t;

  // Field order must match RELEASE_BIT / INDEX_MSB above.
  typedef struct packed {
    logic          rel;
    logic [IW-1:0] idx;
  } event_t;

  function automatic event_t make_event(input logic rel, input logic [IW-1:0] idx);
    event_t ev;
    ev.rel = rel;
    ev.idx = idx;
    return ev;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// First-word-fall-through event queue; head visible the cycle after the push.
// Push when full is refused unless a pop happens in the same cycle; head reads 0 when empty.
module keypad_event_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_dat,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_dat,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == DEPTH_L);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = empty ? '0 : mem[rd_ptr];
  assign level    = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/keypad_event_bridge.sv
// Keypad row scanner + per-key debouncer feeding an event queue; release events only with KEYPAD_RELEASE_EVENT_EN.
// Latency DEBOUNCE_SCANS samples + <=COLS cycles + 1; tx_ready low fills the queue, then events drop and set overflow.
module keypad_event_bridge
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = SCAN_DIV_DEF,
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [ROWS-1:0]             row,
  input  logic [COLS-1:0]             col,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int NKEYS = ROWS * COLS;
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [RW-1:0]   row_idx;
  logic [RW-1:0]   row_nxt;
  logic [NKEYS-1:0] stable;
  logic [CW-1:0]   dbc_cnt [NKEYS];
  logic [COLS-1:0] smp;
  logic [COLS-1:0] cur_stable;
  logic [COLS-1:0] flip;
  logic [COLS-1:0] want;
  logic [COLS-1:0] pend;
  logic [COLS-1:0] pend_rel;
  logic [COLS-1:0] sel;
  logic [RW-1:0]   walk_row;
  ser_state_t      state_q;
  ser_state_t      state_d;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  event_t          push_ev;

  assign tick    = (div_cnt == DIV_LAST);
  assign row_nxt = !tick ? row_idx : ((row_idx == ROW_LAST) ? '0 : row_idx + 1'b1);
  assign smp     = ~col;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      row_idx <= '0;
      row     <= '1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      row_idx <= row_nxt;
      row     <= ~(ROWS'(1) << row_nxt);
    end
  end

  // A key flips when this sample is the DEBOUNCE_SCANS-th consecutive disagreement.
  always_comb begin
    cur_stable = '0;
    flip       = '0;
    for (int c = 0; c < COLS; c++) begin
      cur_stable[c] = stable[int'(row_idx) * COLS + c];
      flip[c]       = (smp[c] != cur_stable[c]) &&
                      (dbc_cnt[int'(row_idx) * COLS + c] == CNT_LAST);
    end
  end

`ifdef KEYPAD_RELEASE_EVENT_EN
  assign want = flip;
`else
  assign want = flip & ~cur_stable;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int k = 0; k < NKEYS; k++) dbc_cnt[k] <= '0;
    end else if (tick) begin
      for (int c = 0; c < COLS; c++) begin
        if ((smp[c] == cur_stable[c]) || flip[c])
          dbc_cnt[int'(row_idx) * COLS + c] <= '0;
        else
          dbc_cnt[int'(row_idx) * COLS + c] <= dbc_cnt[int'(row_idx) * COLS + c] + 1'b1;
        if (flip[c]) stable[int'(row_idx) * COLS + c] <= smp[c];
      end
    end
  end

  // The walk always ends before the next tick, so a tick only ever lands in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend     <= '0;
      pend_rel <= '0;
      walk_row <= '0;
    end else begin
      state_q <= state_d;
      if (tick) begin
        pend     <= want;
        pend_rel <= cur_stable;
        walk_row <= row_idx;
      end else begin
        pend <= pend & ~sel;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel     = '0;
    push    = 1'b0;
    push_ev = '0;
    case (state_q)
      IDLE: begin
        if (tick && (want != '0)) state_d = WALK;
      end
      WALK: begin
        sel  = pend & (~pend + 1'b1);
        push = (pend != '0);
        for (int c = 0; c < COLS; c++) begin
          if (sel[c]) push_ev = make_event(pend_rel[c], IW'(int'(walk_row) * COLS + c));
        end
        if ((pend & ~sel) == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_valid = ~fifo_empty;
  assign pop      = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst)                              overflow <= 1'b0;
    else if (push && fifo_full && !pop)   overflow <= 1'b1;
  end

  keypad_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ev),
    .pop      (pop),
    .head_dat (tx_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

endmodule

// File: tb/tb_keypad_event_bridge.sv
// Bench for keypad_event_bridge: keypad model on row/col, scoreboard of expected event bytes.
module tb_keypad_event_bridge;

  localparam int ROWS = 4;
  localparam int COLS = 4;
`ifdef KEYPAD_RELEASE_EVENT_EN
  localparam int REL_EN = 1;
`else
  localparam int REL_EN = 0;
`endif

  typedef struct {
    int         r;
    int         c;
    logic [7:0] exp_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        overflow;
  logic [2:0]  fifo_level;
  logic [15:0] keys = '0;

  int checks = 0;
  int failures = 0;
  int vld_cycles = 0;
  int cyc = 0;
  int last_pop = 0;
  int pop_gap = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_event_bridge #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(8), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .overflow(overflow), .fifo_level(fifo_level)
  );

  // Pressed key shorts its column to whichever row is currently driven low.
  always_comb begin
    col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row[r] && keys[r*COLS+c]) col[c] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid) vld_cycles++;
      if (tx_valid && tx_ready) begin
        pop_gap  = cyc - last_pop;
        last_pop = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
        end else begin
          check("event_byte", tx_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_row"}, row, 4'hF);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_level"}, fifo_level, 0);
  endtask

  task automatic wait_row_sample(input int r);
    int n = 0;
    while (row[r] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    while (row[r] === 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL row_sample_timeout actual=%0d required=<100", n);
    end
  endtask

  task automatic release_key(input int k, input logic [7:0] b);
    keys[k] = 1'b0;
    if (REL_EN != 0) exp_q.push_back(b | 8'h80);
    settle(160);
    check("drain_release", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    vec_t ovf[5];
    int   n;
    vecs[0] = '{0, 0, 8'h00};
    vecs[1] = '{3, 3, 8'h0F};
    vecs[2] = '{1, 2, 8'h06};
    vecs[3] = '{2, 3, 8'h0B};
    vecs[4] = '{3, 1, 8'h0D};
    ovf[0]  = '{0, 1, 8'h01};
    ovf[1]  = '{1, 1, 8'h05};
    ovf[2]  = '{2, 2, 8'h0A};
    ovf[3]  = '{3, 0, 8'h0C};
    ovf[4]  = '{0, 3, 8'h03};

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    check("row0_after_rst", row, 4'b1110);

    // single press row2/col1, latency measured from the third sample
    wait_row_sample(2);
    vld_cycles = 0;
    keys[9] = 1'b1;
    exp_q.push_back(8'h09);
    wait_row_sample(2);
    wait_row_sample(2);
    check("no_early_event", tx_valid, 0);
    wait_row_sample(2);
    n = 0;
    while (!tx_valid && n < 10) begin @(negedge clk); n++; end
    check("press_latency_ok", (n >= 1 && n <= COLS + 1), 1);
    settle(64);
    check("drain_single", exp_q.size(), 0);
    check("single_valid_cycles", vld_cycles, 1);

    vld_cycles = 0;
    release_key(9, 8'h09);
    check("release_valid_cycles", vld_cycles, REL_EN);

    // bouncing key never reaches the debounce threshold
    vld_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      keys[0] = (i % 2 == 0);
      wait_row_sample(0);
      check("toggle_level", fifo_level, 0);
    end
    keys[0] = 1'b0;
    settle(160);
    check("toggle_no_event", vld_cycles, 0);

    foreach (vecs[i]) begin
      vld_cycles = 0;
      keys[vecs[i].r*COLS + vecs[i].c] = 1'b1;
      exp_q.push_back(vecs[i].exp_b);
      settle(160);
      check("tbl_drain", exp_q.size(), 0);
      check("tbl_valid_cycles", vld_cycles, 1);
      release_key(vecs[i].r*COLS + vecs[i].c, vecs[i].exp_b);
    end

    // overflow: consumer stalled, fifth press dropped
    tx_ready = 1'b0;
    foreach (ovf[i]) begin
      keys[ovf[i].r*COLS + ovf[i].c] = 1'b1;
      if (i < 4) exp_q.push_back(ovf[i].exp_b);
      settle(160);
      check("ovf_level_step", fifo_level, (i < 4) ? i + 1 : 4);
      check("ovf_flag_step", overflow, (i == 4) ? 1 : 0);
    end
    check("ovf_tx_valid", tx_valid, 1);
    check("ovf_head", tx_data, 8'h01);
    settle(20);
    check("ovf_head_stable", tx_data, 8'h01);
    tx_ready = 1'b1;
    settle(20);
    check("ovf_drain", exp_q.size(), 0);
    check("ovf_sticky", overflow, 1);
    foreach (ovf[i]) release_key(ovf[i].r*COLS + ovf[i].c, ovf[i].exp_b);

    // two keys in the same row, same scan
    vld_cycles = 0;
    keys[4] = 1'b1;
    keys[7] = 1'b1;
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h07);
    settle(160);
    check("pair_drain", exp_q.size(), 0);
    check("pair_gap", pop_gap, 1);
    check("pair_valid_cycles", vld_cycles, 2);
    keys[4] = 1'b0;
    keys[7] = 1'b0;
    if (REL_EN != 0) begin
      exp_q.push_back(8'h84);
      exp_q.push_back(8'h87);
    end
    settle(160);
    check("pair_release_drain", exp_q.size(), 0);

    // mid-operation reset with two events queued and row3/col3 held
    tx_ready = 1'b0;
    keys[2] = 1'b1;
    settle(160);
    keys[8] = 1'b1;
    settle(160);
    check("pre_rst_level", fifo_level, 2);
    keys[15] = 1'b1;
    settle(40);
    rst = 1'b1;
    keys[2] = 1'b0;
    keys[8] = 1'b0;
    @(negedge clk);
    check_reset("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    vld_cycles = 0;
    exp_q.push_back(8'h0F);
    tx_ready = 1'b1;
    settle(200);
    check("post_rst_drain", exp_q.size(), 0);
    check("post_rst_valid_cycles", vld_cycles, 1);
    release_key(15, 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
